// File: rtl/fadd_pkg.sv
// Shared definitions for the FloPoCo fadd feeder: word width, exception codes
// and the pairing FSM state type.
package fadd_pkg;

   // Width of a FloPoCo word: 2 exception bits, 1 sign bit, exponent, fraction.
   function automatic int W(input int we, input int wf);
      return we + wf + 3;
   endfunction

   localparam logic [1:0] EXN_ZERO   = 2'b00;
   localparam logic [1:0] EXN_NORMAL = 2'b01;
   localparam logic [1:0] EXN_INF    = 2'b10;
   localparam logic [1:0] EXN_NAN    = 2'b11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } feed_state_t;

endpackage

// File: rtl/fadd_feed_fifo.sv
// First-word-fall-through result FIFO for the fadd feeder. Each entry holds a
// sum together with its end-of-stream flag. The head entry is visible on
// rd_data/rd_last whenever count is non-zero; both read as zero when empty.
module fadd_feed_fifo
   import fadd_pkg::*;
#(
   parameter  int WD    = 11,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [WD-1:0] wr_data,
   input  logic          wr_last,
   input  logic          rd_en,
   output logic [WD-1:0] rd_data,
   output logic          rd_last,
   output logic [AW:0]   count
);

   logic [WD:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_wr;
   logic          do_rd;

   assign do_rd = rd_en && (count != '0);
   // A write into a full FIFO is refused unless a read frees the slot on the same edge.
   assign do_wr = wr_en && !reset && ((count != (AW+1)'(DEPTH)) || do_rd);

   // Storage array; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr] <= {wr_last, wr_data};
      end
   end

   // Pointers wrap naturally at DEPTH (a power of two); count is held on simultaneous read/write.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Head entry presentation, forced to zero while the FIFO is empty.
   always_comb begin
      rd_data = '0;
      rd_last = 1'b0;
      if (count != '0) begin
         rd_data = mem[rd_ptr][WD-1:0];
         rd_last = mem[rd_ptr][WD];
      end else begin
         rd_data = '0;
         rd_last = 1'b0;
      end
   end

endmodule

// File: rtl/fadd_feed.sv
// Pairwise feeder for a fixed-latency FloPoCo fadd core. Consecutive stream
// elements are paired and issued to the core as X/Y; an odd final element is
// paired with zero. Results are tracked through the core pipeline and queued
// in a FWFT FIFO. A credit check on in_ready keeps the non-stallable core from
// ever overrunning the FIFO.
// Optional feature: define FADD_FEED_NAN_FLAG_EN to add the sticky nan_seen
// output, cleared at the end of each dequeued stream.
module fadd_feed
   import fadd_pkg::*;
#(
   parameter  int WE      = 4,
   parameter  int WF      = 4,
   parameter  int LATENCY = 1,
   parameter  int DEPTH   = 4,
   localparam int WD      = W(WE, WF)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   input  logic [WD-1:0] in_data,
   input  logic          in_last,
   output logic          in_ready,
   output logic [WD-1:0] fadd_x,
   output logic [WD-1:0] fadd_y,
   input  logic [WD-1:0] fadd_r,
   output logic          out_valid,
   output logic [WD-1:0] out_data,
   output logic          out_last,
   input  logic          out_ready
`ifdef FADD_FEED_NAN_FLAG_EN
   ,
   output logic          nan_seen
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 2;
   localparam int SW = CW + 1;

   feed_state_t   state;
   feed_state_t   state_nx;
   logic [WD-1:0] hold_a;
   logic [WD-1:0] hold_nx;
   logic          accept;
   logic          complete;
   logic [WD-1:0] pair_x;
   logic [WD-1:0] pair_y;
   logic          pair_last;

   logic               issue_valid;
   logic               issue_last;
   logic [LATENCY-1:0] pipe_valid;
   logic [LATENCY-1:0] pipe_last;
   logic               retire;

   logic [CW-1:0] inflight;
   logic [CW-1:0] inflight_nx;
   logic [AW:0]   fifo_count;
   logic [AW:0]   count_nx;
   logic          fifo_rd;
   logic [SW-1:0] need;

   assign accept  = in_valid && in_ready;
   assign retire  = pipe_valid[LATENCY-1];
   assign fifo_rd = out_valid && out_ready;
   assign out_valid = (fifo_count != '0);

   // Pairing FSM: decide whether this accepted element completes a pair.
   always_comb begin
      state_nx  = state;
      hold_nx   = hold_a;
      complete  = 1'b0;
      pair_x    = '0;
      pair_y    = '0;
      pair_last = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept && in_last) begin
               complete  = 1'b1;
               pair_x    = in_data;
               pair_last = 1'b1;
            end else if (accept) begin
               state_nx = ST_HOLD;
               hold_nx  = in_data;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         ST_HOLD: begin
            if (accept) begin
               complete  = 1'b1;
               pair_x    = hold_a;
               pair_y    = in_data;
               pair_last = in_last;
               state_nx  = ST_IDLE;
               hold_nx   = '0;
            end else begin
               state_nx = ST_HOLD;
            end
         end
         default: begin
            state_nx = ST_IDLE;
            hold_nx  = '0;
         end
      endcase
   end

   // FSM state and held first operand.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_IDLE;
         hold_a <= '0;
      end else begin
         state  <= state_nx;
         hold_a <= hold_nx;
      end
   end

   // Issue register: X/Y carry a pair for exactly one cycle, zero otherwise.
   always_ff @(posedge clk) begin
      if (reset) begin
         fadd_x      <= '0;
         fadd_y      <= '0;
         issue_valid <= 1'b0;
         issue_last  <= 1'b0;
      end else begin
         fadd_x      <= complete ? pair_x : '0;
         fadd_y      <= complete ? pair_y : '0;
         issue_valid <= complete;
         issue_last  <= complete && pair_last;
      end
   end

   // Track each issued pair through the core so R is captured at the right edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         pipe_valid <= '0;
         pipe_last  <= '0;
      end else begin
         pipe_valid[0] <= issue_valid;
         pipe_last[0]  <= issue_last;
         for (int k = 1; k < LATENCY; k++) begin
            pipe_valid[k] <= pipe_valid[k-1];
            pipe_last[k]  <= pipe_last[k-1];
         end
      end
   end

   // Next-cycle occupancy: pairs owed to the FIFO plus entries already in it.
   always_comb begin
      inflight_nx = inflight;
      count_nx    = fifo_count;
      if (complete && !retire) begin
         inflight_nx = inflight + 1'b1;
      end else if (!complete && retire) begin
         inflight_nx = inflight - 1'b1;
      end else begin
         inflight_nx = inflight;
      end
      if (retire && !fifo_rd) begin
         count_nx = fifo_count + 1'b1;
      end else if (!retire && fifo_rd) begin
         count_nx = fifo_count - 1'b1;
      end else begin
         count_nx = fifo_count;
      end
      need = SW'(inflight_nx) + SW'(count_nx) + SW'(1'b1);
   end

   // Credit counter and registered ready: accept only if one more pair still fits.
   always_ff @(posedge clk) begin
      if (reset) begin
         inflight <= '0;
         in_ready <= 1'b0;
      end else begin
         inflight <= inflight_nx;
         in_ready <= (need <= SW'(DEPTH));
      end
   end

   fadd_feed_fifo #(
      .WD    (WD),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (retire),
      .wr_data (fadd_r),
      .wr_last (pipe_last[LATENCY-1]),
      .rd_en   (out_ready),
      .rd_data (out_data),
      .rd_last (out_last),
      .count   (fifo_count)
   );

`ifdef FADD_FEED_NAN_FLAG_EN
   // Sticky NaN flag over a dequeued stream; a NaN on the last result keeps it set.
   always_ff @(posedge clk) begin
      if (reset) begin
         nan_seen <= 1'b0;
      end else if (fifo_rd) begin
         if (out_data[WD-1:WD-2] == EXN_NAN) begin
            nan_seen <= 1'b1;
         end else if (out_last) begin
            nan_seen <= 1'b0;
         end else begin
            nan_seen <= nan_seen;
         end
      end else begin
         nan_seen <= nan_seen;
      end
   end
`endif

endmodule

// File: tb/tb_fadd_feed.sv
// Self-checking bench for fadd_feed (WE=4, WF=4, LATENCY=1, DEPTH=4) with a
// behavioural one-cycle fadd core. Expected sums go into a scoreboard queue
// when the completing element is accepted and are compared on dequeue.
module tb_fadd_feed;
   import fadd_pkg::*;

   localparam int WD = 11;

   typedef struct packed {
      logic [WD-1:0] data;
      logic          last;
   } res_t;

   typedef struct {
      logic [WD-1:0] a;
      logic [WD-1:0] b;
      logic          single;
      logic [WD-1:0] sum;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic [WD-1:0] in_data;
   logic          in_last;
   logic          in_ready;
   logic [WD-1:0] fadd_x;
   logic [WD-1:0] fadd_y;
   logic [WD-1:0] fadd_r = '0;
   logic          out_valid;
   logic [WD-1:0] out_data;
   logic          out_last;
   logic          out_ready;
`ifdef FADD_FEED_NAN_FLAG_EN
   logic          nan_seen;
`endif

   int   checks = 0;
   int   errors = 0;
   res_t sb[$];
   logic          held_v = 1'b0;
   logic [WD-1:0] held = '0;

   fadd_feed #(.WE(4), .WF(4), .LATENCY(1), .DEPTH(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .fadd_x    (fadd_x),
      .fadd_y    (fadd_y),
      .fadd_r    (fadd_r),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_ready (out_ready)
`ifdef FADD_FEED_NAN_FLAG_EN
      ,
      .nan_seen  (nan_seen)
`endif
   );

   always #5 clk = ~clk;

   // Behavioural FloPoCo value helpers (bias 7, 4-bit fraction).
   function automatic real to_real(input logic [WD-1:0] w);
      real v;
      int  e;
      if (w[10:9] == 2'b00) return 0.0;
      v = 1.0 + real'(w[3:0]) / 16.0;
      e = int'(w[7:4]) - 7;
      while (e > 0) begin v = v * 2.0; e--; end
      while (e < 0) begin v = v / 2.0; e++; end
      return w[8] ? -v : v;
   endfunction

   function automatic logic [WD-1:0] from_real(input real v_in);
      real  v;
      int   e;
      logic s;
      if (v_in == 0.0) return '0;
      s = (v_in < 0.0);
      v = s ? -v_in : v_in;
      e = 7;
      while (v >= 2.0) begin v = v / 2.0; e++; end
      while (v < 1.0) begin v = v * 2.0; e--; end
      return {2'b01, s, 4'(e), 4'($rtoi((v - 1.0) * 16.0))};
   endfunction

   function automatic logic [WD-1:0] fmodel(input logic [WD-1:0] x, input logic [WD-1:0] y);
      if (x[10:9] == 2'b11 || y[10:9] == 2'b11) return {2'b11, 9'b0};
      if (x[10:9] == 2'b10) return x;
      if (y[10:9] == 2'b10) return y;
      return from_real(to_real(x) + to_real(y));
   endfunction

   // Core model: one cycle from X/Y to R.
   always @(posedge clk) fadd_r <= fmodel(fadd_x, fadd_y);

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   // Scoreboard monitor: every dequeue is compared against the oldest expectation.
   always @(negedge clk) begin
      res_t e;
      if (out_valid && out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL out_unexpected got=%b last=%b expected none", out_data, out_last);
         end else begin
            e = sb.pop_front();
            if (out_data !== e.data || out_last !== e.last) begin
               errors++;
               $display("FAIL out_data got=%b/%b expected=%b/%b", out_data, out_last, e.data, e.last);
            end
         end
      end
   end

   // Offer one element (called at a negedge); on acceptance update the pairing
   // model, push the expected sum and check the issued X/Y pair.
   task automatic send(input logic [WD-1:0] d, input logic l, input logic use_tbl,
                       input logic [WD-1:0] tsum, input int bound, input logic must,
                       output logic ok);
      logic          comp;
      logic [WD-1:0] ex_x;
      logic [WD-1:0] ex_y;
      res_t          r;
      in_valid = 1'b1; in_data = d; in_last = l;
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         if (in_ready) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      if (must) begin
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL accept got=not_accepted expected=accepted data=%b", d);
         end
      end
      if (!ok) begin
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 in_valid = 1'b0; in_data = '0; in_last = 1'b0;
      comp = held_v || l;
      ex_x = comp ? (held_v ? held : d) : '0;
      ex_y = (comp && held_v) ? d : '0;
      if (comp) begin
         r.data = use_tbl ? tsum : fmodel(ex_x, ex_y);
         r.last = held_v ? l : 1'b1;
         sb.push_back(r);
         held_v = 1'b0;
      end else begin
         held = d; held_v = 1'b1;
      end
      @(negedge clk);
      chk("fadd_x", 32'(fadd_x), 32'(ex_x));
      chk("fadd_y", 32'(fadd_y), 32'(ex_y));
   endtask

   task automatic wait_drain();
      logic done = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (sb.size() == 0 && !out_valid) begin done = 1'b1; break; end
         @(negedge clk);
      end
      chk("drain", 32'(done), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t          tbl [6];
      logic [WD-1:0] bp  [10];
      logic          ok;
      int            acc;
      int            stale;

      tbl[0] = '{11'b01010000000, 11'b01010001000, 1'b0, 11'b01010010100}; // 2+3=5
      tbl[1] = '{11'b01010000000, 11'b00000000000, 1'b1, 11'b01010000000}; // odd 2.0
      tbl[2] = '{11'b01001110000, 11'b01001110000, 1'b0, 11'b01010000000}; // 1+1=2
      tbl[3] = '{11'b00000000000, 11'b01010001000, 1'b0, 11'b01010001000}; // 0+3=3
      tbl[4] = '{11'b01010000000, 11'b01110000000, 1'b0, 11'b00000000000}; // 2-2=0
      tbl[5] = '{11'b01001111000, 11'b01001100000, 1'b0, 11'b01010000000}; // 1.5+0.5=2
      bp[0] = 11'b01001110000; bp[1] = 11'b01010000000; bp[2] = 11'b01010001000;
      bp[3] = 11'b01001111000; bp[4] = 11'b01001100000; bp[5] = 11'b01010000000;
      bp[6] = 11'b01001110000; bp[7] = 11'b01010001000; bp[8] = 11'b01110000000;
      bp[9] = 11'b01010000000;

      reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_fadd_x", 32'(fadd_x), 32'd0);
      chk("rst_fadd_y", 32'(fadd_y), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("rel_in_ready", 32'(in_ready), 32'd1);

      // Sum scenario with exact result timing.
      send(tbl[0].a, 1'b0, 1'b0, '0, 40, 1'b1, ok);
      send(tbl[0].b, 1'b1, 1'b1, tbl[0].sum, 40, 1'b1, ok);
      chk("sum_valid_t0", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("sum_valid_t1", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("sum_valid_t2", 32'(out_valid), 32'd1);
      chk("sum_data", 32'(out_data), 32'(tbl[0].sum));
      chk("sum_last", 32'(out_last), 32'd1);
      wait_drain();

      // Table-driven pairs and odd streams.
      for (int v = 0; v < 6; v++) begin
         if (tbl[v].single) begin
            send(tbl[v].a, 1'b1, 1'b1, tbl[v].sum, 40, 1'b1, ok);
         end else begin
            send(tbl[v].a, 1'b0, 1'b0, '0, 40, 1'b1, ok);
            send(tbl[v].b, 1'b1, 1'b1, tbl[v].sum, 40, 1'b1, ok);
         end
      end
      wait_drain();

      // Backpressure: only DEPTH results' worth of elements may be accepted.
      @(posedge clk); #1 out_ready = 1'b0;
      @(negedge clk);
      acc = 0;
      for (int i = 0; i < 10; i++) begin
         send(bp[i], 1'(i % 2), 1'b0, '0, 6, 1'b0, ok);
         if (!ok) break;
         acc++;
      end
      chk("bp_accepted", 32'(acc), 32'd8);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_fifo_full", 32'(dut.fifo_count), 32'd4);
      @(posedge clk); #1 out_ready = 1'b1;
      @(negedge clk);
      for (int i = acc; i < 10; i++) begin
         send(bp[i], 1'(i % 2), 1'b0, '0, 40, 1'b1, ok);
      end
      wait_drain();

      // Simultaneous write and read leave the count unchanged; credit caps at DEPTH.
      @(posedge clk); #1 out_ready = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 8; i++) send(bp[i], 1'(i % 2), 1'b0, '0, 40, 1'b1, ok);
      @(posedge clk); #1 out_ready = 1'b1;
      chk("sim_count_before", 32'(dut.fifo_count), 32'd3);
      @(posedge clk); #1 out_ready = 1'b0;
      chk("sim_count_after", 32'(dut.fifo_count), 32'd3);
      @(negedge clk);
      send(bp[2], 1'b0, 1'b0, '0, 40, 1'b1, ok);
      send(bp[3], 1'b1, 1'b0, '0, 40, 1'b1, ok);
      repeat (3) @(negedge clk);
      chk("sim_count_full", 32'(dut.fifo_count), 32'd4);
      chk("sim_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1 out_ready = 1'b1;
      @(negedge clk);
      wait_drain();

      // Reset mid-stream after three accepted elements.
      send(bp[0], 1'b0, 1'b0, '0, 40, 1'b1, ok);
      send(bp[1], 1'b1, 1'b0, '0, 40, 1'b1, ok);
      send(bp[2], 1'b0, 1'b0, '0, 40, 1'b1, ok);
      reset = 1'b1;
      sb.delete();
      held_v = 1'b0;
      @(negedge clk);
      chk("mid_out_valid", 32'(out_valid), 32'd0);
      chk("mid_state", 32'(dut.state), 32'(ST_IDLE));
      chk("mid_in_ready", 32'(in_ready), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("mid_rel_ready", 32'(in_ready), 32'd1);
      stale = 0;
      for (int i = 0; i < 6; i++) begin
         if (out_valid) stale++;
         @(negedge clk);
      end
      chk("mid_stale", 32'(stale), 32'd0);

`ifdef FADD_FEED_NAN_FLAG_EN
      // NaN flag: set by a NaN result, cleared by a later non-NaN last dequeue.
      send(11'b11000000000, 1'b0, 1'b0, '0, 40, 1'b1, ok);
      send(11'b01010000000, 1'b1, 1'b0, '0, 40, 1'b1, ok);
      wait_drain();
      @(negedge clk);
      chk("nan_set", 32'(nan_seen), 32'd1);
      send(11'b01010000000, 1'b0, 1'b0, '0, 40, 1'b1, ok);
      send(11'b01010001000, 1'b1, 1'b0, '0, 40, 1'b1, ok);
      wait_drain();
      @(negedge clk);
      chk("nan_clear", 32'(nan_seen), 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
